// File: rtl/mdio_pkg.sv
// mdio_pkg: shared FSM states, opcodes and field widths for the MDIO slave
package mdio_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int TA_LEN = 2;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA1, S_TA2, S_DATA
    } state_e;
endpackage

// File: rtl/mdio_preamble_det.sv
// mdio_preamble_det: saturating preamble ones-counter; MDIO_PREAMBLE_SUPPRESS_EN accepts start after one 1-bit
module mdio_preamble_det #(
    parameter int PREAMBLE_LEN = 32
) (
    input  logic mdc,
    input  logic rst,
    input  logic en_i,
    input  logic mdi_i,
    output logic sof_o
);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] THR = 6'd1;
`else
    localparam logic [5:0] THR = 6'(PREAMBLE_LEN);
`endif
    localparam logic [5:0] SAT = 6'(PREAMBLE_LEN);
    logic [5:0] cnt_q, cnt_d;
    assign sof_o = en_i && !mdi_i && cnt_q >= THR;
    // Ones since the last 0 while idle; cleared by any 0 or whenever a frame is in progress
    always_comb cnt_d = (en_i && mdi_i) ? (cnt_q == SAT ? cnt_q : cnt_q + 6'd1) : '0;
    // Counter register
    always_ff @(posedge mdc) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mdio_mmd_slave.sv
// mdio_mmd_slave: Clause 22 MDIO slave turning serial frames into register strobes
module mdio_mmd_slave
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR     = 5'd1,
    parameter int                PREAMBLE_LEN = 32
) (
    input  logic              mdc,
    input  logic              rst,
    input  logic              mdi,
    output logic              mdo,
    output logic              mdo_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d, reg_wdata_q, reg_wdata_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d, field;
    logic              rd_q, rd_d, ign_q, ign_d, mdo_q, mdo_d, mdo_en_q, mdo_en_d;
    logic              reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, err_q, err_d;
    logic              sof, drive;
    logic [1:0]        op;

    mdio_preamble_det #(.PREAMBLE_LEN(PREAMBLE_LEN)) u_pre (
        .mdc   (mdc),
        .rst   (rst),
        .en_i  (state_q == S_IDLE),
        .mdi_i (mdi),
        .sof_o (sof)
    );

    assign drive     = rd_q && !ign_q;
    assign op        = {sh_q[0], mdi};
    assign field     = {sh_q[ADDR_W-2:0], mdi};
    assign mdo       = mdo_q;
    assign mdo_en    = mdo_en_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign frame_err = err_q;

    // Frame decoder: one mdi bit per cycle, header bits and data share one shift register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - 4'd1;
        sh_d        = {sh_q[DATA_W-2:0], mdi};
        rd_d        = rd_q;
        ign_d       = ign_q;
        mdo_d       = 1'b1;
        mdo_en_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: state_d = sof ? S_ST : S_IDLE;
            S_ST: begin
                err_d   = !mdi;
                state_d = mdi ? S_OP : S_IDLE;
                cnt_d   = 4'd1;
            end
            S_OP: if (cnt_q == '0) begin
                rd_d    = op == OP_READ;
                err_d   = op != OP_READ && op != OP_WRITE;
                state_d = err_d ? S_IDLE : S_PHYAD;
                cnt_d   = 4'(ADDR_W - 1);
            end
            S_PHYAD: if (cnt_q == '0) begin
                ign_d   = field != PHY_ADDR;
                state_d = S_REGAD;
                cnt_d   = 4'(ADDR_W - 1);
            end
            S_REGAD: if (cnt_q == '0) begin
                state_d    = S_TA1;
                reg_rd_d   = drive;
                reg_addr_d = ign_q ? reg_addr_q : field;
            end
            S_TA1: begin
                state_d  = S_TA2;
                sh_d     = drive ? reg_rdata : sh_d;
                mdo_d    = !drive;
                mdo_en_d = drive;
            end
            S_TA2: begin
                state_d  = S_DATA;
                cnt_d    = 4'(DATA_W - 1);
                mdo_d    = drive ? sh_q[DATA_W-1] : 1'b1;
                mdo_en_d = drive;
            end
            S_DATA: begin
                mdo_d       = (drive && cnt_q != '0) ? sh_q[DATA_W-1] : 1'b1;
                mdo_en_d    = drive && cnt_q != '0;
                state_d     = cnt_q == '0 ? S_IDLE : S_DATA;
                reg_wr_d    = cnt_q == '0 && !rd_q && !ign_q;
                reg_wdata_d = reg_wr_d ? sh_d : reg_wdata_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge mdc) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            rd_q        <= 1'b0;
            ign_q       <= 1'b0;
            mdo_q       <= 1'b1;
            mdo_en_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rd_q        <= rd_d;
            ign_q       <= ign_d;
            mdo_q       <= mdo_d;
            mdo_en_q    <= mdo_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_mdio_mmd_slave.sv
// tb_mdio_mmd_slave: table-driven and randomized frames checked against a frame-level model
module tb_mdio_mmd_slave;
    import mdio_pkg::*;
    localparam int LEN = 32;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int THR = 1;
`else
    localparam int THR = LEN;
`endif
    localparam int K31 = (31 >= THR) ? 1 : 0;
    localparam int K1  = (1 >= THR) ? 1 : 0;

    typedef struct {
        int         pre;
        logic [1:0] st;
        logic [1:0] op;
        logic [4:0] phy;
        logic [4:0] ra;
        logic [15:0] data;
        int         kind;
    } frame_t;

    logic        mdc = 1'b0, rst = 1'b1, mdi = 1'b0;
    logic        mdo, mdo_en, reg_wr, reg_rd, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic [15:0] mem [32];
    logic [15:0] ref_mem [32];
    logic        bq [$];
    int          checks = 0, errors = 0;

    always #5 mdc = ~mdc;

    mdio_mmd_slave #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(LEN)) dut (
        .mdc(mdc), .rst(rst), .mdi(mdi), .mdo(mdo), .mdo_en(mdo_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    function automatic logic [15:0] init_val(int i);
        return i == 2 ? 16'h1234 : 16'(i * 16'h0301 + 16'h0F0F);
    endfunction

    assign reg_rdata = mem[reg_addr];
    always @(posedge mdc) begin
        if (rst) for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        else if (reg_wr) mem[reg_addr] <= reg_wdata;
    end

    // 0 none, 1 write served, 2 read served, 3 frame error
    function automatic int model_kind(frame_t f);
        if (f.pre < THR) return 0;
        if (f.st != 2'b01) return 3;
        if (f.op != OP_READ && f.op != OP_WRITE) return 3;
        if (f.phy != 5'd1) return 0;
        return f.op == OP_READ ? 2 : 1;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic build(frame_t f, int kind);
        bq.delete();
        for (int i = 0; i < f.pre; i++) bq.push_back(1'b1);
        bq.push_back(f.st[1]);
        bq.push_back(f.st[0]);
        if (!(kind == 3 && f.st != 2'b01)) begin
            bq.push_back(f.op[1]);
            bq.push_back(f.op[0]);
            if (kind != 3) begin
                for (int i = 4; i >= 0; i--) bq.push_back(f.phy[i]);
                for (int i = 4; i >= 0; i--) bq.push_back(f.ra[i]);
                bq.push_back(1'b1);
                bq.push_back(1'b0);
                for (int i = TA_LEN + 13; i >= 0; i--) bq.push_back(f.data[i]);
            end
        end
        repeat (3) bq.push_back(1'b0);
    endtask

    task automatic run_frame(string tag, frame_t f, int kind);
        logic [127:0] en_v = '0, exp_en = '0;
        logic [16:0]  rdw = '0;
        logic [4:0]   wa = '0, ra_obs = '0;
        logic [15:0]  wd = '0;
        int wr_i = -1, wr_n = 0, rd_i = -1, rd_n = 0, er_i = -1, er_n = 0;
        build(f, kind);
        for (int i = 0; i < bq.size(); i++) begin
            mdi = bq[i];
            @(negedge mdc);
            en_v[i] = mdo_en;
            if (mdo_en) rdw = {rdw[15:0], mdo};
            if (reg_wr) begin
                wr_n++;
                if (wr_i < 0) begin wr_i = i; wa = reg_addr; wd = reg_wdata; end
            end
            if (reg_rd) begin
                rd_n++;
                if (rd_i < 0) begin rd_i = i; ra_obs = reg_addr; end
            end
            if (frame_err) begin
                er_n++;
                if (er_i < 0) er_i = i;
            end
        end
        if (kind == 2) for (int i = f.pre + 14; i <= f.pre + 30; i++) exp_en[i] = 1'b1;
        check({tag, " mdo_en"}, en_v, exp_en);
        check({tag, " wr_cnt"}, 128'(wr_n), 128'(kind == 1));
        check({tag, " rd_cnt"}, 128'(rd_n), 128'(kind == 2));
        check({tag, " err_cnt"}, 128'(er_n), 128'(kind == 3));
        if (kind == 1) begin
            check({tag, " wr_idx"}, 128'(wr_i), 128'(f.pre + 31));
            check({tag, " wr_addr"}, 128'(wa), 128'(f.ra));
            check({tag, " wr_data"}, 128'(wd), 128'(f.data));
            ref_mem[f.ra] = f.data;
        end
        if (kind == 2) begin
            check({tag, " rd_idx"}, 128'(rd_i), 128'(f.pre + 13));
            check({tag, " rd_addr"}, 128'(ra_obs), 128'(f.ra));
            check({tag, " rd_data"}, 128'(rdw), 128'({1'b0, ref_mem[f.ra]}));
        end
        if (kind == 3) check({tag, " err_idx"}, 128'(er_i), 128'(f.st != 2'b01 ? f.pre + 1 : f.pre + 3));
    endtask

    initial begin
        frame_t tbl [12];
        frame_t f;
        int lo, seen;
        tbl[0]  = '{pre: 32, st: 2'b01, op: OP_WRITE, phy: 5'd1,  ra: 5'h0A, data: 16'hBEEF, kind: 1};
        tbl[1]  = '{pre: 32, st: 2'b01, op: OP_READ,  phy: 5'd1,  ra: 5'h02, data: 16'hFFFF, kind: 2};
        tbl[2]  = '{pre: 32, st: 2'b01, op: OP_READ,  phy: 5'h07, ra: 5'h02, data: 16'h0000, kind: 0};
        tbl[3]  = '{pre: 32, st: 2'b01, op: OP_READ,  phy: 5'd1,  ra: 5'h0A, data: 16'h5A5A, kind: 2};
        tbl[4]  = '{pre: 31, st: 2'b01, op: OP_WRITE, phy: 5'd1,  ra: 5'h03, data: 16'h00FF, kind: K31};
        tbl[5]  = '{pre: 1,  st: 2'b01, op: OP_WRITE, phy: 5'd1,  ra: 5'h03, data: 16'h00FF, kind: K1};
        tbl[6]  = '{pre: 32, st: 2'b01, op: 2'b11,    phy: 5'd1,  ra: 5'h04, data: 16'h1111, kind: 3};
        tbl[7]  = '{pre: 32, st: 2'b01, op: OP_WRITE, phy: 5'd1,  ra: 5'h05, data: 16'h0001, kind: 1};
        tbl[8]  = '{pre: 40, st: 2'b00, op: OP_WRITE, phy: 5'd1,  ra: 5'h06, data: 16'h8000, kind: 3};
        tbl[9]  = '{pre: 32, st: 2'b01, op: 2'b00,    phy: 5'd1,  ra: 5'h07, data: 16'h2222, kind: 3};
        tbl[10] = '{pre: 32, st: 2'b01, op: OP_WRITE, phy: 5'h1F, ra: 5'h05, data: 16'hDEAD, kind: 0};
        tbl[11] = '{pre: 32, st: 2'b01, op: OP_READ,  phy: 5'd1,  ra: 5'h03, data: 16'h0000, kind: 2};
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge mdc);
        check("reset_outputs", 128'({mdo, mdo_en, reg_wr, reg_rd, frame_err, reg_addr, reg_wdata}),
              128'({1'b1, 4'b0, 5'b0, 16'b0}));
        rst = 1'b0;
        for (int i = 0; i < 12; i++) run_frame($sformatf("tbl%0d", i), tbl[i], tbl[i].kind);
        lo = (THR == 1) ? 1 : 24;
        for (int n = 0; n < 40; n++) begin
            f.pre  = int'($urandom_range(40, lo));
            f.st   = ($urandom_range(9, 0) == 0) ? 2'b00 : 2'b01;
            f.op   = 2'($urandom);
            f.phy  = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'd1;
            f.ra   = 5'($urandom);
            f.data = 16'($urandom);
            f.kind = model_kind(f);
            run_frame($sformatf("rnd%0d", n), f, f.kind);
        end
        f = '{pre: 32, st: 2'b01, op: OP_READ, phy: 5'd1, ra: 5'h02, data: 16'h0000, kind: 2};
        build(f, 2);
        for (int i = 0; i <= f.pre + 22; i++) begin
            mdi = bq[i];
            @(negedge mdc);
        end
        check("rst_pre_drive", 128'(mdo_en), 128'(1));
        rst = 1'b1;
        mdi = bq[f.pre + 23];
        @(negedge mdc);
        check("rst_abort", 128'({mdo_en, reg_rd, reg_wr, mdo}), 128'(4'b0001));
        rst = 1'b0;
        seen = 0;
        for (int i = f.pre + 24; i < bq.size(); i++) begin
            mdi = bq[i];
            @(negedge mdc);
            seen += int'(mdo_en) + int'(reg_rd) + int'(reg_wr) + int'(frame_err);
        end
        check("rst_quiet", 128'(seen), 128'(0));
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        run_frame("post_rst", f, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
